pps_trig_monitor: RTL and testbench

PPS_TRIG_MONITOR -- requirements
Module: pps_trig_monitor

---
 rtl/pps_pkg.sv | 42 ++++
 rtl/edge_sync.sv | 40 ++++
 rtl/pps_trig_monitor.sv | 192 +++++++++++++++++++
 tb/tb_pps_trig_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pps_pkg.sv
// ---------------------------------------------------------------------------
// pps_pkg
//   Definitions shared by the PPS trigger monitor and the PPS pulse generator.
//   Contents:
//     state_t          - monitor FSM state encoding (also exported on o_cstate)
//     DEF_PULSE_NUM    - default number of trigger pulses per PPS window
//     DEF_HALF_PERIOD  - default high/low width of one trigger pulse, in clocks
//     sat_inc()        - 32-bit increment that sticks at all-ones
//     width_ok()       - tolerance test of a measured width
// ---------------------------------------------------------------------------
package pps_pkg;

    typedef enum logic [3:0] {
        WAIT_PPS  = 4'd0,
        ARMED     = 4'd1,
        MEAS_HIGH = 4'd2,
        MEAS_LOW  = 4'd3
    } state_t;

    localparam int unsigned DEF_PULSE_NUM   = 100;
    localparam int unsigned DEF_HALF_PERIOD = 500000;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Counters stop at all-ones rather than wrapping back to a small value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

    // Bounds are carried in 33 bits so half+tol cannot overflow, and the
    // lower bound clamps to 0 when tol exceeds half.
    function automatic logic width_ok(input logic [31:0]  width,
                                      input int unsigned  half,
                                      input int unsigned  tol);
        logic [32:0] lo_bound;
        logic [32:0] hi_bound;
        lo_bound = (half > tol) ? 33'(half - tol) : 33'd0;
        hi_bound = 33'(half) + 33'(tol);
        return ({1'b0, width} >= lo_bound) && ({1'b0, width} <= hi_bound);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
//   Brings one asynchronous input into the i_clk domain through a 2-FF
//   synchronizer, then compares against one more register to find edges.
//   rise/fall are combinational from registers, so the consuming logic acts
//   on the 3rd rising clock edge after the input transition.
//   Ports:
//     i_clk    - system clock
//     i_rst_n  - asynchronous active-low reset
//     async_in - asynchronous input
//     rise     - one-clock pulse, synchronized input went 0 -> 1
//     fall     - one-clock pulse, synchronized input went 1 -> 0
// ---------------------------------------------------------------------------
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              edge_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
            edge_reg <= sync_reg[STAGES-1];
        end
    end

    assign rise =  sync_reg[STAGES-1] & ~edge_reg;
    assign fall = ~sync_reg[STAGES-1] &  edge_reg;

endmodule

// File: rtl/pps_trig_monitor.sv
// ---------------------------------------------------------------------------
// pps_trig_monitor
//   Checks a trigger pulse train against the PPS: each PPS rising edge
//   closes the current window and opens the next. Within a window the block
//   counts trigger rising edges and measures every complete high and low
//   width. At each window close a one-clock o_valid strobe presents the
//   count, the last high/low widths and the count/width error flags.
//   If no PPS edge arrives for PPS_TIMEOUT clocks, o_pps_lost is raised and
//   the FSM parks in WAIT_PPS until the next PPS edge.
//   Ports:
//     i_clk, i_rst_n  - clock, asynchronous active-low reset
//     SYNC            - asynchronous PPS input
//     i_trig          - asynchronous trigger pulse train
//     o_valid         - one-clock strobe: report outputs refreshed
//     o_pulse_count   - trigger rising edges in the last closed window
//     o_high_cnt      - last complete high width in the last closed window
//     o_low_cnt       - last complete low width in the last closed window
//     o_count_err     - o_pulse_count differed from PULSE_NUM
//     o_width_err     - some width in the last window was out of tolerance
//     o_pps_lost      - level, PPS timeout has occurred
//     o_cstate        - current FSM state
// ---------------------------------------------------------------------------
module pps_trig_monitor
    import pps_pkg::*;
#(
    parameter int unsigned PULSE_NUM   = DEF_PULSE_NUM,
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned TOL         = 1000,
    parameter int unsigned PPS_TIMEOUT = 150000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        SYNC,
    input  logic        i_trig,
    output logic        o_valid,
    output logic [31:0] o_pulse_count,
    output logic [31:0] o_high_cnt,
    output logic [31:0] o_low_cnt,
    output logic        o_count_err,
    output logic        o_width_err,
    output logic        o_pps_lost,
    output logic [3:0]  o_cstate
);

    localparam int          N_IN         = 2;
    localparam int          IDX_PPS      = 0;
    localparam int          IDX_TRIG     = 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(PPS_TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_MAX  = 32'(PPS_TIMEOUT);
    localparam logic [31:0] PULSE_EXP    = 32'(PULSE_NUM);

    // ---------------- input synchronizers ----------------
    logic [N_IN-1:0] async_in;
    logic [N_IN-1:0] in_rise;
    logic [N_IN-1:0] in_fall;

    assign async_in = {i_trig, SYNC};

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_sync
            edge_sync u_edge_sync (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .async_in (async_in[gi]),
                .rise     (in_rise[gi]),
                .fall     (in_fall[gi])
            );
        end
    endgenerate

    logic pps_rise;
    logic trig_rise;
    logic trig_fall;
    logic pps_fall_unused;

    assign pps_rise        = in_rise[IDX_PPS];
    assign pps_fall_unused = in_fall[IDX_PPS];
    assign trig_rise       = in_rise[IDX_TRIG];
    assign trig_fall       = in_fall[IDX_TRIG];

    // ---------------- window state ----------------
    state_t      state_reg;
    logic [31:0] width_cnt_reg;
    logic [31:0] pulse_cnt_reg;
    logic [31:0] high_last_reg;
    logic [31:0] low_last_reg;
    logic        width_err_reg;
    logic [31:0] timeout_reg;

    // The counter is cleared on the clock that sees the edge, so the width
    // being closed on this clock is one more than the stored value.
    logic [31:0] width_next;
    logic        width_in_tol;

    assign width_next   = sat_inc(width_cnt_reg);
    assign width_in_tol = width_ok(width_next, HALF_PERIOD, TOL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= WAIT_PPS;
            width_cnt_reg <= '0;
            pulse_cnt_reg <= '0;
            high_last_reg <= '0;
            low_last_reg  <= '0;
            width_err_reg <= 1'b0;
            timeout_reg   <= '0;
            o_valid       <= 1'b0;
            o_pulse_count <= '0;
            o_high_cnt    <= '0;
            o_low_cnt     <= '0;
            o_count_err   <= 1'b0;
            o_width_err   <= 1'b0;
            o_pps_lost    <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            if (pps_rise) begin
                timeout_reg <= '0;
            end else if (timeout_reg != TIMEOUT_MAX) begin
                timeout_reg <= timeout_reg + 32'd1;
            end

            if (pps_rise) begin
                o_pps_lost <= 1'b0;
                // Only a window that was actually open produces a report.
                if (state_reg != WAIT_PPS) begin
                    o_valid       <= 1'b1;
                    o_pulse_count <= pulse_cnt_reg;
                    o_high_cnt    <= high_last_reg;
                    o_low_cnt     <= low_last_reg;
                    o_count_err   <= (pulse_cnt_reg != PULSE_EXP);
                    o_width_err   <= width_err_reg;
                end
                // Restart accumulation; a pulse in progress is abandoned.
                width_cnt_reg <= '0;
                high_last_reg <= '0;
                low_last_reg  <= '0;
                width_err_reg <= 1'b0;
                // A trigger rise on the same clock belongs to the new window.
                if (trig_rise) begin
                    pulse_cnt_reg <= 32'd1;
                    state_reg     <= MEAS_HIGH;
                end else begin
                    pulse_cnt_reg <= '0;
                    state_reg     <= ARMED;
                end
            end else if (timeout_reg == TIMEOUT_LAST) begin
                // Fires once: the counter then parks at TIMEOUT_MAX.
                o_pps_lost <= 1'b1;
                state_reg  <= WAIT_PPS;
            end else begin
                case (state_reg)
                    ARMED: begin
                        if (trig_rise) begin
                            pulse_cnt_reg <= sat_inc(pulse_cnt_reg);
                            width_cnt_reg <= '0;
                            state_reg     <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (trig_fall) begin
                            high_last_reg <= width_next;
                            if (!width_in_tol) width_err_reg <= 1'b1;
                            width_cnt_reg <= '0;
                            state_reg     <= MEAS_LOW;
                        end else begin
                            width_cnt_reg <= width_next;
                        end
                    end
                    MEAS_LOW: begin
                        if (trig_rise) begin
                            low_last_reg  <= width_next;
                            if (!width_in_tol) width_err_reg <= 1'b1;
                            pulse_cnt_reg <= sat_inc(pulse_cnt_reg);
                            width_cnt_reg <= '0;
                            state_reg     <= MEAS_HIGH;
                        end else begin
                            width_cnt_reg <= width_next;
                        end
                    end
                    default: begin
                        // WAIT_PPS: idle until a PPS edge
                    end
                endcase
            end
        end
    end

    assign o_cstate = state_reg;

endmodule

// File: tb/tb_pps_trig_monitor.sv
// ---------------------------------------------------------------------------
// tb_pps_trig_monitor
//   Directed stimulus drives PPS windows and trigger pulse trains. Each time
//   a window is about to be closed the expected report is pushed onto a
//   queue; an independent monitor pops and compares on every o_valid.
//   Level outputs (reset state, pps_lost, state) are checked inline.
// ---------------------------------------------------------------------------
module tb_pps_trig_monitor;

    localparam int unsigned P_PULSE_NUM = 4;
    localparam int unsigned P_HALF      = 10;
    localparam int unsigned P_TOL       = 1;
    localparam int unsigned P_TIMEOUT   = 200;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        sync_in = 1'b0;
    logic        trig_in = 1'b0;
    logic        o_valid;
    logic [31:0] o_pulse_count;
    logic [31:0] o_high_cnt;
    logic [31:0] o_low_cnt;
    logic        o_count_err;
    logic        o_width_err;
    logic        o_pps_lost;
    logic [3:0]  o_cstate;

    typedef struct packed {
        logic [31:0] count;
        logic [31:0] high;
        logic [31:0] low;
        logic        count_err;
        logic        width_err;
    } rpt_t;

    rpt_t exp_q[$];
    rpt_t mon_act;
    rpt_t mon_exp;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rpt    = 0;

    always #5 i_clk = ~i_clk;

    pps_trig_monitor #(
        .PULSE_NUM   (P_PULSE_NUM),
        .HALF_PERIOD (P_HALF),
        .TOL         (P_TOL),
        .PPS_TIMEOUT (P_TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .SYNC          (sync_in),
        .i_trig        (trig_in),
        .o_valid       (o_valid),
        .o_pulse_count (o_pulse_count),
        .o_high_cnt    (o_high_cnt),
        .o_low_cnt     (o_low_cnt),
        .o_count_err   (o_count_err),
        .o_width_err   (o_width_err),
        .o_pps_lost    (o_pps_lost),
        .o_cstate      (o_cstate)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then step just past the edge to drive inputs.
    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic pulse(input int high_w, input int low_w);
        trig_in = 1'b1;
        tick(high_w);
        trig_in = 1'b0;
        tick(low_w);
    endtask

    task automatic pps();
        sync_in = 1'b1;
        tick(2);
        sync_in = 1'b0;
    endtask

    task automatic expect_rpt(input int cnt, input int hi, input int lo,
                              input logic cerr, input logic werr);
        rpt_t r;
        r.count     = 32'(cnt);
        r.high      = 32'(hi);
        r.low       = 32'(lo);
        r.count_err = cerr;
        r.width_err = werr;
        exp_q.push_back(r);
    endtask

    // Scoreboard monitor: every o_valid cycle consumes one expected report.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            n_rpt++;
            n_checks++;
            mon_act = {o_pulse_count, o_high_cnt, o_low_cnt, o_count_err, o_width_err};
            if (exp_q.size() == 0) begin
                $display("FAIL report%0d: unexpected o_valid, got count=%0d high=%0d low=%0d cerr=%0b werr=%0b, expected no report",
                         n_rpt, mon_act.count, mon_act.high, mon_act.low, mon_act.count_err, mon_act.width_err);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act === mon_exp) begin
                    n_pass++;
                    $display("report%0d: count=%0d high=%0d low=%0d cerr=%0b werr=%0b ok",
                             n_rpt, mon_act.count, mon_act.high, mon_act.low, mon_act.count_err, mon_act.width_err);
                end else begin
                    $display("FAIL report%0d: got count=%0d high=%0d low=%0d cerr=%0b werr=%0b, expected count=%0d high=%0d low=%0d cerr=%0b werr=%0b",
                             n_rpt, mon_act.count, mon_act.high, mon_act.low, mon_act.count_err, mon_act.width_err,
                             mon_exp.count, mon_exp.high, mon_exp.low, mon_exp.count_err, mon_exp.width_err);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_valid",     32'(o_valid),     32'd0);
        check("rst_count",     o_pulse_count,    32'd0);
        check("rst_high",      o_high_cnt,       32'd0);
        check("rst_low",       o_low_cnt,        32'd0);
        check("rst_count_err", 32'(o_count_err), 32'd0);
        check("rst_width_err", 32'(o_width_err), 32'd0);
        check("rst_pps_lost",  32'(o_pps_lost),  32'd0);
        check("rst_cstate",    32'(o_cstate),    32'd0);
        i_rst_n = 1'b1;
        tick(2);

        // First PPS opens a window without a report
        pps();
        tick(3);
        check("open_cstate", 32'(o_cstate), 32'd1);

        // Nominal window
        repeat (4) pulse(10, 10);
        expect_rpt(4, 10, 10, 1'b0, 1'b0);
        pps();
        tick(3);

        // Count error: 3 pulses
        repeat (3) pulse(10, 10);
        expect_rpt(3, 10, 10, 1'b1, 1'b0);
        pps();
        tick(3);

        // High width 12 out of tolerance, sticky while later pulses are good
        pulse(12, 10);
        repeat (3) pulse(10, 10);
        expect_rpt(4, 10, 10, 1'b0, 1'b1);
        pps();
        tick(3);

        // High width 11 at the tolerance edge
        repeat (3) pulse(10, 10);
        pulse(11, 10);
        expect_rpt(4, 11, 10, 1'b0, 1'b0);
        pps();
        tick(3);

        // Low width 8 out of tolerance
        pulse(10, 8);
        repeat (3) pulse(10, 10);
        expect_rpt(4, 10, 10, 1'b0, 1'b1);
        pps();
        tick(3);

        // PPS and trigger rise on the same clock
        repeat (4) pulse(10, 10);
        expect_rpt(4, 10, 10, 1'b0, 1'b0);
        sync_in = 1'b1;
        trig_in = 1'b1;
        tick(2);
        sync_in = 1'b0;
        tick(8);
        trig_in = 1'b0;
        tick(10);
        repeat (2) pulse(10, 10);
        expect_rpt(3, 10, 10, 1'b1, 1'b0);
        pps();

        // Timeout: PPS acted on 1 clock after this point, lost 200 clocks later
        tick(195);
        check("pre_timeout_lost", 32'(o_pps_lost), 32'd0);
        tick(10);
        check("timeout_lost",      32'(o_pps_lost),  32'd1);
        check("timeout_cstate",    32'(o_cstate),    32'd0);
        check("hold_count",        o_pulse_count,    32'd3);
        check("hold_count_err",    32'(o_count_err), 32'd1);

        // Next PPS clears lost, opens a window, no report
        pps();
        tick(3);
        check("recover_lost",   32'(o_pps_lost), 32'd0);
        check("recover_cstate", 32'(o_cstate),   32'd1);

        // Reset while measuring a high pulse
        trig_in = 1'b1;
        tick(5);
        check("meas_high_cstate", 32'(o_cstate), 32'd2);
        i_rst_n = 1'b0;
        #1;
        check("arst_count",  o_pulse_count,    32'd0);
        check("arst_high",   o_high_cnt,       32'd0);
        check("arst_low",    o_low_cnt,        32'd0);
        check("arst_cerr",   32'(o_count_err), 32'd0);
        check("arst_werr",   32'(o_width_err), 32'd0);
        check("arst_valid",  32'(o_valid),     32'd0);
        check("arst_lost",   32'(o_pps_lost),  32'd0);
        check("arst_cstate", 32'(o_cstate),    32'd0);
        trig_in = 1'b0;
        tick(2);

        check("reports_outstanding", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
